// File: rtl/sgmii_rx_deser_align.sv
// SGMII receive deserializer: shifts in one bit per clock, aligns on K28.x commas and runs LOS/ACQ/SYNC.
// Define SGMII_DES_STATS_EN to build the saturating realignment counter behind realign_count.
module sgmii_rx_deser_align #(
    parameter int ACQ_COMMAS    = 3,
    parameter int COMMA_TIMEOUT = 255,
    parameter int STATS_WIDTH   = 16
) (
    input  logic                   ser_sgmii_clk,
    input  logic                   reset,
    input  logic                   sgmii_rx_p,
    output logic [9:0]             code_group,
    output logic                   code_group_valid,
    output logic                   code_group_comma,
    output logic                   sync_ok,
    output logic [STATS_WIDTH-1:0] realign_count
);
    typedef enum logic [1:0] {
        ST_LOS  = 2'd0,
        ST_ACQ  = 2'd1,
        ST_SYNC = 2'd2
    } state_t;

    localparam logic [4:0]  ACQ_TGT = 5'(ACQ_COMMAS);
    localparam logic [16:0] TO_TGT  = 17'(COMMA_TIMEOUT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [9:0]  r_sr;
    logic [3:0]  r_phase;
    logic [3:0]  w_phase_nxt;
    logic [3:0]  r_acq_cnt;
    logic [3:0]  w_acq_cnt_nxt;
    logic [15:0] r_to_cnt;
    logic [15:0] w_to_cnt_nxt;
    logic [9:0]  r_code_group;
    logic        r_valid;
    logic        r_comma;
    logic        r_sync_ok;
    logic        w_comma;
    logic        w_boundary;
    logic        w_realign;
    logic        w_emit;
    logic [4:0]  w_acq_inc;
    logic [16:0] w_to_inc;

    assign w_comma    = (r_sr[9:3] == 7'b0011111) || (r_sr[9:3] == 7'b1100000);
    assign w_boundary = (r_phase == 4'd9);
    assign w_acq_inc  = {1'b0, r_acq_cnt} + 5'd1;
    assign w_to_inc   = {1'b0, r_to_cnt} + 17'd1;

    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = w_boundary ? 4'd0 : r_phase + 4'd1;
        w_acq_cnt_nxt = r_acq_cnt;
        w_to_cnt_nxt  = r_to_cnt;
        w_realign     = 1'b0;
        w_emit        = 1'b0;
        case (r_state)
            ST_LOS: begin
                if (w_comma) begin
                    w_realign     = 1'b1;
                    w_emit        = 1'b1;
                    w_acq_cnt_nxt = 4'd1;
                    w_to_cnt_nxt  = 16'd0;
                    w_state_nxt   = (ACQ_TGT == 5'd1) ? ST_SYNC : ST_ACQ;
                end
            end
            default: begin
                if (w_comma && !w_boundary) begin
                    w_realign     = 1'b1;
                    w_emit        = 1'b1;
                    w_acq_cnt_nxt = 4'd1;
                    w_to_cnt_nxt  = 16'd0;
                    w_state_nxt   = ST_ACQ;
                end else if (w_boundary) begin
                    w_emit = 1'b1;
                    // An aligned comma on the timeout boundary keeps the link up.
                    if (w_comma) begin
                        w_to_cnt_nxt = 16'd0;
                        if (r_state == ST_ACQ) begin
                            w_acq_cnt_nxt = w_acq_inc[3:0];
                            if (w_acq_inc >= ACQ_TGT) begin
                                w_state_nxt = ST_SYNC;
                            end
                        end
                    end else if (w_to_inc >= TO_TGT) begin
                        w_state_nxt   = ST_LOS;
                        w_to_cnt_nxt  = 16'd0;
                        w_acq_cnt_nxt = 4'd0;
                    end else begin
                        w_to_cnt_nxt = w_to_inc[15:0];
                    end
                end
            end
        endcase
        if (w_realign) begin
            w_phase_nxt = 4'd0;
        end
    end

    always_ff @(posedge ser_sgmii_clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_LOS;
            r_sr         <= 10'd0;
            r_phase      <= 4'd0;
            r_acq_cnt    <= 4'd0;
            r_to_cnt     <= 16'd0;
            r_code_group <= 10'd0;
            r_valid      <= 1'b0;
            r_comma      <= 1'b0;
            r_sync_ok    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sr      <= {r_sr[8:0], sgmii_rx_p};
            r_phase   <= w_phase_nxt;
            r_acq_cnt <= w_acq_cnt_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_valid   <= w_emit;
            r_comma   <= w_emit && w_comma;
            r_sync_ok <= (w_state_nxt == ST_SYNC);
            if (w_emit) begin
                r_code_group <= r_sr;
            end
        end
    end

    assign code_group       = r_code_group;
    assign code_group_valid = r_valid;
    assign code_group_comma = r_comma;
    assign sync_ok          = r_sync_ok;

`ifdef SGMII_DES_STATS_EN
    logic [STATS_WIDTH-1:0] r_realign_cnt;
    logic                   w_cnt_inc;

    // Realignments out of LOS are initial acquisitions, not slips.
    assign w_cnt_inc = w_realign && (r_state != ST_LOS);

    always_ff @(posedge ser_sgmii_clk or negedge reset) begin
        if (!reset) begin
            r_realign_cnt <= '0;
        end else if (w_cnt_inc && (r_realign_cnt != '1)) begin
            r_realign_cnt <= r_realign_cnt + {{(STATS_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign realign_count = r_realign_cnt;
`else
    assign realign_count = '0;
`endif

endmodule

// File: tb/tb_sgmii_rx_deser_align.sv
// Bench for sgmii_rx_deser_align: line stimulus from a record table, strobes checked against an expected queue.
`timescale 1ns/1ps
module tb_sgmii_rx_deser_align;
    localparam logic [9:0] K285 = 10'b0011111010;
    localparam logic [9:0] D162 = 10'b1001000101;
    localparam logic [9:0] D215 = 10'b1010101010;
`ifdef SGMII_DES_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    // One line segment: nbits right-justified bits sent MSB first, plus the strobe expected at its end.
    typedef struct {
        int         nbits;
        logic [9:0] bits;
        logic       strobe;
        logic       sync;
    } vec_t;

    typedef struct packed {
        logic [31:0] e_cyc;
        logic [9:0]  grp;
        logic        comma;
        logic        sync;
    } exp_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        rx     = 1'b0;
    logic [9:0]  cg;
    logic        cg_v;
    logic        cg_c;
    logic        sync_ok;
    logic [3:0]  rc;
    int unsigned cyc    = 0;
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b0;
    logic [9:0]  hist   = '0;
    exp_t        exp_q[$];
    vec_t        tbl[$];

    sgmii_rx_deser_align #(
        .ACQ_COMMAS   (3),
        .COMMA_TIMEOUT(8),
        .STATS_WIDTH  (4)
    ) dut (
        .ser_sgmii_clk   (clk),
        .reset           (rst_n),
        .sgmii_rx_p      (rx),
        .code_group      (cg),
        .code_group_valid(cg_v),
        .code_group_comma(cg_c),
        .sync_ok         (sync_ok),
        .realign_count   (rc)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp_v);
        end
    endtask

    function automatic logic is_comma(input logic [9:0] g);
        return (g[9:3] == 7'b0011111) || (g[9:3] == 7'b1100000);
    endfunction

    function automatic void add(input int nb, input logic [9:0] b, input logic s, input logic y);
        vec_t v;
        v.nbits  = nb;
        v.bits   = b;
        v.strobe = s;
        v.sync   = y;
        tbl.push_back(v);
    endfunction

    // Driver
    task automatic drive_bit(input logic b);
        @(negedge clk);
        rx   = b;
        hist = {hist[8:0], b};
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        for (int i = v.nbits - 1; i >= 0; i--) begin
            drive_bit(v.bits[i]);
        end
        if (v.strobe) begin
            // Last bit is sampled at the next edge; the registered strobe follows one edge later.
            e.e_cyc = 32'(cyc + 2);
            e.grp   = hist;
            e.comma = is_comma(hist);
            e.sync  = v.sync;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(tbl[i]);
        end
        tbl.delete();
    endtask

    // Scoreboard
    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                while (exp_q.size() > 0 && exp_q[0].e_cyc < 32'(cyc)) begin
                    e = exp_q.pop_front();
                    check("strobe_missing", 32'(cyc), e.e_cyc);
                end
                if (cg_v) begin
                    if (exp_q.size() == 0) begin
                        check("strobe_unexpected", 32'(cg_v), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("strobe_cycle", 32'(cyc), e.e_cyc);
                        check("code_group", 32'(cg), 32'(e.grp));
                        check("code_group_comma", 32'(cg_c), 32'(e.comma));
                        check("sync_ok_at_strobe", 32'(sync_ok), 32'(e.sync));
                    end
                end
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_code_group"}, 32'(cg), 32'd0);
        check({tag, "_valid"}, 32'(cg_v), 32'd0);
        check({tag, "_comma"}, 32'(cg_c), 32'd0);
        check({tag, "_sync_ok"}, 32'(sync_ok), 32'd0);
        check({tag, "_realign_count"}, 32'(rc), 32'd0);
    endtask

    initial begin
        fork
            monitor_loop();
        join_none
        fork
            begin
                #2000000;
                $display("FAIL watchdog: time limit reached at cyc %0d", cyc);
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Acquisition from LOS: no strobes before the first comma, sync on the 3rd K28.5.
        add(10, D215, 1'b0, 1'b0);
        add(10, K285, 1'b1, 1'b0);
        add(10, D162, 1'b1, 1'b0);
        add(10, K285, 1'b1, 1'b0);
        add(10, D162, 1'b1, 1'b0);
        add(10, K285, 1'b1, 1'b1);
        add(10, D162, 1'b1, 1'b1);
        add(10, K285, 1'b1, 1'b1);
        add(10, D162, 1'b1, 1'b1);
        // One extra bit: a shifted window, then the off-boundary K28.5 realigns.
        add(1, 10'd0, 1'b0, 1'b0);
        add(9, {1'b0, K285[9:1]}, 1'b1, 1'b1);
        add(1, {9'd0, K285[0]}, 1'b1, 1'b0);
        add(10, D162, 1'b1, 1'b0);
        add(10, K285, 1'b1, 1'b0);
        add(10, D162, 1'b1, 1'b0);
        add(10, K285, 1'b1, 1'b1);
        run_tbl();
        check("realign_after_slip", 32'(rc), STATS_ON ? 32'd1 : 32'd0);

        // Comma timeout of 8: a comma on the 8th boundary holds sync, 8 plain groups drop it.
        for (int i = 0; i < 7; i++) add(10, D215, 1'b1, 1'b1);
        add(10, K285, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) add(10, D215, 1'b1, 1'b1);
        add(10, D215, 1'b1, 1'b0);
        add(10, D215, 1'b0, 1'b0);
        add(10, D215, 1'b0, 1'b0);
        add(10, K285, 1'b1, 1'b0);
        add(10, D162, 1'b1, 1'b0);
        add(10, K285, 1'b1, 1'b0);
        add(10, D162, 1'b1, 1'b0);
        add(10, K285, 1'b1, 1'b1);
        add(10, D162, 1'b1, 1'b1);
        run_tbl();
        check("realign_after_timeout", 32'(rc), STATS_ON ? 32'd1 : 32'd0);

        // Reset in the middle of a group while in SYNC.
        for (int i = 9; i >= 5; i--) drive_bit(D215[i]);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        rx   = 1'b0;
        hist = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        add(5, 10'b0000001010, 1'b0, 1'b0);
        add(10, K285, 1'b1, 1'b0);
        add(10, D162, 1'b1, 1'b0);
        add(10, K285, 1'b1, 1'b0);
        add(10, D162, 1'b1, 1'b0);
        add(10, K285, 1'b1, 1'b1);
        add(10, D162, 1'b1, 1'b1);
        run_tbl();

        // Twenty slips, each followed by re-acquisition.
        for (int s = 0; s < 20; s++) begin
            add(1, 10'd0, 1'b0, 1'b0);
            add(9, {1'b0, K285[9:1]}, 1'b1, 1'b1);
            add(1, {9'd0, K285[0]}, 1'b1, 1'b0);
            add(10, D162, 1'b1, 1'b0);
            add(10, K285, 1'b1, 1'b0);
            add(10, D162, 1'b1, 1'b0);
            add(10, K285, 1'b1, 1'b1);
            run_tbl();
            if (s == 9) begin
                check("realign_after_10_slips", 32'(rc), STATS_ON ? 32'd10 : 32'd0);
            end
        end
        check("realign_saturated", 32'(rc), STATS_ON ? 32'd15 : 32'd0);

        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        check("expected_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sgmii_rx_deser_align.md
# sgmii_rx_deser_align

Receive-side SGMII deserializer and comma aligner. It sits directly downstream of the serial 8b/10b line driven onto `sgmii_rx_p`. It shifts in one bit per clock, finds code-group boundaries from K28.x comma patterns, and runs a simplified acquire/lose synchronization state machine. Its output is aligned 10-bit code groups for the 8b/10b decoder and the GMII-side frame receiver.

## Interface
Parameters:
- `ACQ_COMMAS`, 3: consecutive boundary-aligned commas needed to declare sync (range 1..15).
- `COMMA_TIMEOUT`, 255: code groups without an aligned comma before sync is dropped (range 1..65535).
- `STATS_WIDTH`, 16: width of the realignment counter.

Ports:
- `ser_sgmii_clk`, in, 1: bit clock. One serial bit is sampled per rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `sgmii_rx_p`, in, 1: serial line. The first bit received is bit 9 (`a`) of the code group.
- `code_group`, out, 10: aligned code group, MSB-first.
- `code_group_valid`, out, 1: one-cycle strobe when `code_group` is updated.
- `code_group_comma`, out, 1: high together with the strobe when `code_group[9:3]` is 0011111 or 1100000.
- `sync_ok`, out, 1: high in state SYNC.
- `realign_count`, out, `STATS_WIDTH`: saturating count of realignment events. Tied to 0 unless `SGMII_DES_STATS_EN` is defined.

## Operation
Shift register:
- `sr[9:0]` updates every edge as `sr <= {sr[8:0], sgmii_rx_p}`.

Comma detection:
- `comma_now` is asserted when `sr[9:3]` equals 0011111 or 1100000.
- It is evaluated on the registered `sr` each cycle.

Phase counter:
- `phase` runs 0..9 and wraps.
- A boundary is the cycle where `phase == 9`, i.e. `sr` holds one whole aligned group.
- A realignment forces `phase` to 0 on the next edge, which makes the comma cycle a boundary.

States: LOS, ACQ, SYNC.
- **LOS**
  - `comma_now` at any phase → realign, `acq_cnt = 1`, go to ACQ (or directly to SYNC if `ACQ_COMMAS == 1`).
  - The realignment counter is not incremented.
- **ACQ**
  - `comma_now` on a boundary → `acq_cnt++`. When `acq_cnt` reaches `ACQ_COMMAS`, go to SYNC.
  - `comma_now` off a boundary → realign, `acq_cnt = 1`, `realign_count++`.
- **SYNC**
  - `comma_now` off a boundary → realign, go to ACQ with `acq_cnt = 1`, `realign_count++`.

Comma timeout:
- `to_cnt` counts boundaries since the last boundary-aligned comma in ACQ/SYNC.
- The boundary on which `to_cnt` reaches `COMMA_TIMEOUT` → go to LOS, clear `to_cnt` and `acq_cnt`.
- If an aligned comma and the timeout fall on the same boundary, the comma wins and `to_cnt` resets to 0.

Output:
- In ACQ/SYNC, every boundary (including the realign cycle itself) registers `code_group <= sr`, `code_group_comma <= comma_now`, and pulses `code_group_valid`.
- In LOS, no strobes are produced and `code_group` holds its last value.

Counter:
- `realign_count` saturates at all-ones.

## Timing
Reset:
- While `reset = 0`, all state clears asynchronously.
- Reset values: `sr` 0, `phase` 0, state LOS, `acq_cnt` 0, `to_cnt` 0.
- Output reset values: `code_group` 0, `code_group_valid` 0, `code_group_comma` 0, `sync_ok` 0, `realign_count` 0.

Latency:
- The last bit of a group is sampled at edge N, so the group is in `sr` after N.
- Outputs update at edge N+1. Bit-to-output latency is 2 edges.
- Strobe spacing is exactly 10 cycles while aligned.

State outputs:
- `sync_ok` changes at the same edge as the state register.
- It is therefore coincident with the strobe of the comma group that completes acquisition.

Reset mid-group:
- The partial group is discarded.
- Re-acquisition needs `ACQ_COMMAS` new commas.

## Configuration
- `SGMII_DES_STATS_EN` defined: the `STATS_WIDTH`-bit saturating realignment counter is built and drives `realign_count`.
- Not defined: no counter flops are built, and `realign_count` is constant 0.

## Test plan
- **Acquisition:** reset, then a repeated /I2/ pair (K28.5 0011111010, D16.2 1001000101) MSB-first.
  - `sync_ok` rises with the strobe of the 3rd K28.5.
  - Strobes every 10 cycles alternate 0011111010 (comma=1) and 1001000101 (comma=0).
- **Bit slip in SYNC:** insert one extra bit.
  - On the next off-boundary comma, `sync_ok` falls, `realign_count = 1` (with stats), and the K28.5 strobe occurs at the new phase.
  - Sync returns after 2 further aligned commas.
- **Comma timeout:** with `COMMA_TIMEOUT = 8`, after sync send only D21.5 1010101010.
  - `sync_ok` falls at the 8th non-comma boundary; strobes stop.
  - The same stimulus with a K28.5 as the 8th group keeps `sync_ok = 1`.
- **Reset mid-group in SYNC:** pull `reset` low for 3 cycles in the middle of a group.
  - All outputs go to 0 immediately.
  - After release, `sync_ok` stays 0 until the 3rd K28.5.
- **Saturation:** with `SGMII_DES_STATS_EN` and `STATS_WIDTH = 4`, apply 20 slips, each followed by re-acquisition → `realign_count = 15`.
- **Stats disabled:** without the macro, the same stimulus → `realign_count = 0`.
